// File: rtl/color_mix_packer_pkg.sv
// Shared types and constants for the RGBA -> RGB565 pixel packer.
package color_mix_packer_pkg;

    // Two-pixel packing state: no pixel held, or low half held awaiting its partner.
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // Output pixel and beat geometry.
    localparam int PIX_W  = 16;
    localparam int DATA_W = 32;
    localparam int KEEP_W = 4;
    localparam int BEAT_W = DATA_W + KEEP_W + 1;  // {tlast, tkeep, tdata}

    localparam logic [KEEP_W-1:0] KEEP_FULL = 4'b1111;
    localparam logic [KEEP_W-1:0] KEEP_HALF = 4'b0011;

    // Channel slot index inside s_axis_tdata, counted from the LSB end.
    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_G = 2;
    localparam int CH_R = 3;

    // Bundle one output beat into the word stored in the skid buffer.
    function automatic logic [BEAT_W-1:0] pack_beat(
        input logic              last,
        input logic [KEEP_W-1:0] keep,
        input logic [PIX_W-1:0]  hi,
        input logic [PIX_W-1:0]  lo
    );
        return {last, keep, hi, lo};
    endfunction

endpackage

// File: rtl/color_mix_packer_skid.sv
// Two-entry output skid buffer with a registered input ready.
// Ready is computed from the next occupancy so it never depends
// combinationally on out_ready.
module color_mix_packer_skid #(
    parameter int DATA_WIDTH = 37
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push;
    logic                  pop;

    assign push      = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // Idle output shows zero so the bus is quiet in and after reset.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Control state: pointers, occupancy and the registered ready.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Beat storage; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/color_mix_packer.sv
// Converts signed saturated RGBA pixels to RGB565 and packs two pixels per
// 32-bit AXI-Stream beat, flushing a lone pixel early when tlast is seen.
module color_mix_packer
    import color_mix_packer_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 9,
    parameter int COLOR_R_WIDTH   = 5,
    parameter int COLOR_G_WIDTH   = 6,
    parameter int COLOR_B_WIDTH   = 5
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [KEEP_W-1:0]            m_axis_tkeep,
    output logic                         m_axis_tlast
);

    localparam int MAG_W = SUB_PIXEL_WIDTH - 1;

    // Negative channels clamp to zero; non-negative keep their magnitude bits.
    function automatic logic [MAG_W-1:0] clamp_mag(
        input logic signed [SUB_PIXEL_WIDTH-1:0] c
    );
        if (c < 0) return '0;
        return c[MAG_W-1:0];
    endfunction

    logic signed [SUB_PIXEL_WIDTH-1:0] chan_r;
    logic signed [SUB_PIXEL_WIDTH-1:0] chan_g;
    logic signed [SUB_PIXEL_WIDTH-1:0] chan_b;
    logic        [MAG_W-1:0]           mag_r;
    logic        [MAG_W-1:0]           mag_g;
    logic        [MAG_W-1:0]           mag_b;
    logic        [PIX_W-1:0]           px_p0;
    logic                              unused_alpha;

    logic                              accept;
    pack_state_t                       state;
    pack_state_t                       state_next;
    logic                              load_low;
    logic        [PIX_W-1:0]           low_p1;
    logic                              push;
    logic        [BEAT_W-1:0]          beat;
    logic        [BEAT_W-1:0]          out_beat;

    assign chan_r = s_axis_tdata[CH_R*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
    assign chan_g = s_axis_tdata[CH_G*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
    assign chan_b = s_axis_tdata[CH_B*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];
    // Alpha is carried on the bus but has no place in RGB565.
    assign unused_alpha = ^s_axis_tdata[CH_A*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH];

    // Stage p0: clamp, then truncate each magnitude to its top field bits.
    assign mag_r = clamp_mag(chan_r);
    assign mag_g = clamp_mag(chan_g);
    assign mag_b = clamp_mag(chan_b);
    assign px_p0 = {mag_r[MAG_W-1 -: COLOR_R_WIDTH],
                    mag_g[MAG_W-1 -: COLOR_G_WIDTH],
                    mag_b[MAG_W-1 -: COLOR_B_WIDTH]};

    assign accept = s_axis_tvalid && s_axis_tready;

    // Pack state register; reset drops any held low-half pixel.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= EMPTY;
        else        state <= state_next;
    end

    // Next pack state: a lone pixel waits in HALF until its partner or tlast arrives.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept && !s_axis_tlast) state_next = HALF;
            HALF:    if (accept)                  state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Pack outputs: which beat (if any) enters the skid buffer this cycle.
    always_comb begin
        push     = 1'b0;
        load_low = 1'b0;
        beat     = '0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        push = 1'b1;
                        beat = pack_beat(1'b1, KEEP_HALF, '0, px_p0);
                    end else begin
                        load_low = 1'b1;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    push = 1'b1;
                    beat = pack_beat(s_axis_tlast, KEEP_FULL, px_p0, low_p1);
                end
            end
            default: begin
                push     = 1'b0;
                load_low = 1'b0;
            end
        endcase
    end

    // Stage p1: low-half pixel held until its partner shows up.
    always_ff @(posedge aclk) begin
        if (load_low) low_p1 <= px_p0;
    end

    // Output skid buffer; s_axis_tready is its registered ready.
    color_mix_packer_skid #(
        .DATA_WIDTH(BEAT_W)
    ) u_skid (
        .clk       (aclk),
        .areset    (areset),
        .in_valid  (push),
        .in_ready  (s_axis_tready),
        .in_data   (beat),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (out_beat)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_beat;

endmodule

// File: tb/tb_color_mix_packer.sv
// Bench for color_mix_packer: directed vectors plus randomized traffic
// checked against a pixel-level packing model.
module tb_color_mix_packer;

    localparam int SPW = 9;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_tvalid;
    logic          s_tready;
    logic [4*SPW-1:0] s_tdata;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic [36:0]   m_beat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nbeats = 0;
    int beat_cyc [$];
    logic [36:0] exp_q [$];
    logic [15:0] pend;
    bit          pend_v = 0;
    bit          prev_stall = 0;
    logic [36:0] prev_beat;
    logic        last_tlast;

    color_mix_packer #(
        .SUB_PIXEL_WIDTH(SPW),
        .COLOR_R_WIDTH(5),
        .COLOR_G_WIDTH(6),
        .COLOR_B_WIDTH(5)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast)
    );

    assign m_beat = {m_tlast, m_tkeep, m_tdata};

    always #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference conversion: clamp negatives to 0, scale 8-bit magnitude to field width.
    function automatic logic [15:0] to565(input logic [4*SPW-1:0] d);
        int r, g, b;
        r = $signed(d[35:27]);
        g = $signed(d[26:18]);
        b = $signed(d[17:9]);
        if (r < 0) r = 0;
        if (g < 0) g = 0;
        if (b < 0) b = 0;
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // Monitor and model: beats out are compared in order against expected beats.
    initial forever begin
        @(negedge aclk);
        if (areset) begin
            exp_q.delete();
            pend_v = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("hold stable", {m_tvalid, m_beat}, {1'b1, prev_beat});
            if (m_tvalid && m_tready) begin
                nbeats++;
                beat_cyc.push_back(cyc);
                last_tlast = m_tlast;
                if (exp_q.size() == 0) chk("extra beat", {1'b1, m_beat}, 38'h0);
                else                   chk("beat", m_beat, exp_q.pop_front());
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = m_beat;
            if (s_tvalid && s_tready) begin
                logic [15:0] px;
                px = to565(s_tdata);
                if (pend_v) begin
                    exp_q.push_back({s_tlast, 4'hF, px, pend});
                    pend_v = 0;
                end else if (s_tlast) begin
                    exp_q.push_back({1'b1, 4'h3, 16'h0000, px});
                end else begin
                    pend   = px;
                    pend_v = 1;
                end
            end
        end
    end

    // Present one pixel and hold it until accepted; returns just after the accepting edge.
    task automatic send_px(input int r, input int g, input int b, input int a, input bit last);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        s_tdata  = {r[8:0], g[8:0], b[8:0], a[8:0]};
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!done) begin
            @(negedge aclk);
            if (s_tready) begin
                @(posedge aclk);
                #1;
                done = 1;
            end else begin
                @(posedge aclk);
                #1;
                n++;
                if (n > 200) begin
                    chk("send timeout", 1, 0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    function automatic int rnd_ch();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    initial begin
        int nb0, c0;
        bit saw_low, took;

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;

        // Reset state
        #3;
        chk("rst s_tready", s_tready, 0);
        chk("rst m_tvalid", m_tvalid, 0);
        chk("rst m_tdata",  m_tdata,  0);
        chk("rst m_tkeep",  m_tkeep,  0);
        chk("rst m_tlast",  m_tlast,  0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("release s_tready", s_tready, 1);
        m_tready = 1'b1;

        // Pair
        send_px(255, 128, -5, 77, 0);
        send_px(0, 0, 255, 3, 0);
        chk("pair latency", m_tvalid, 1);
        chk("pair tdata", m_tdata, 32'h001F_FC00);
        chk("pair tkeep", m_tkeep, 4'b1111);
        chk("pair tlast", m_tlast, 0);
        idle(2);

        // Odd flush
        send_px(255, 128, 0, 0, 1);
        chk("flush latency", m_tvalid, 1);
        chk("flush tdata", m_tdata, 32'h0000_FC00);
        chk("flush tkeep", m_tkeep, 4'b0011);
        chk("flush tlast", m_tlast, 1);
        idle(2);

        // Saturation, alpha ignored
        send_px(-256, -256, -256, 100, 0);
        send_px(255, 255, 255, -256, 1);
        chk("sat tdata", m_tdata, 32'hFFFF_0000);
        chk("sat tkeep", m_tkeep, 4'b1111);
        chk("sat tlast", m_tlast, 1);
        idle(2);

        // Backpressure: 8-pixel burst with downstream stalled for 5 cycles
        nb0 = nbeats;
        m_tready = 1'b0;
        saw_low = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_px(rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch(), i == 7);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            begin
                repeat (5) begin
                    @(negedge aclk);
                    if (!s_tready) saw_low = 1;
                    @(posedge aclk);
                end
                #1 m_tready = 1'b1;
            end
        join
        idle(10);
        chk("bp ready fell", saw_low, 1);
        chk("bp beat count", nbeats - nb0, 4);
        chk("bp drained", exp_q.size(), 0);

        // Throughput: 16 back-to-back pixels
        beat_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 16; i++) send_px(rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch(), i == 15);
        chk("tput input cycles", cyc - c0, 16);
        idle(4);
        chk("tput beat count", beat_cyc.size(), 8);
        for (int i = 1; i < beat_cyc.size(); i++)
            chk("tput spacing", beat_cyc[i] - beat_cyc[i-1], 2);
        chk("tput last tlast", last_tlast, 1);

        // Reset mid-pair with a beat still queued
        m_tready = 1'b0;
        send_px(255, 128, 0, 0, 1);
        send_px(10, 20, 30, 0, 0);
        chk("pre-reset m_tvalid", m_tvalid, 1);
        areset = 1'b1;
        #1;
        chk("midrst m_tvalid", m_tvalid, 0);
        chk("midrst s_tready", s_tready, 0);
        chk("midrst m_tdata", m_tdata, 0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("midrst release ready", s_tready, 1);
        chk("midrst no stale beat", m_tvalid, 0);
        m_tready = 1'b1;
        send_px(0, 0, 255, 0, 0);
        send_px(255, 0, 0, 0, 1);
        chk("midrst beat0 tdata", m_tdata, 32'hF800_001F);
        chk("midrst beat0 tkeep", m_tkeep, 4'b1111);
        chk("midrst beat0 tlast", m_tlast, 1);
        idle(2);

        // Randomized traffic with random backpressure
        took = 0;
        s_tvalid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            if (!s_tvalid || took) begin
                s_tvalid = ($urandom_range(0, 2) != 0);
                s_tdata  = {9'(rnd_ch()), 9'(rnd_ch()), 9'(rnd_ch()), 9'(rnd_ch())};
                s_tlast  = ($urandom_range(0, 3) == 0);
            end
            @(negedge aclk);
            took = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        idle(10);
        chk("random drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
